// File: rtl/bus_arb_pkg.sv
// Shared constants and types for the 32-source round-robin bus arbiter.
package bus_arb_pkg;

    localparam int NUM_REQ = 32;
    localparam int IDX_W   = 5;

    typedef logic [IDX_W-1:0] idx_t;

    // Arbiter states
    localparam logic IDLE  = 1'b0;
    localparam logic OWNED = 1'b1;

    // Pointer reset value: index 0 gets first priority out of reset
    localparam idx_t LAST_RST = 5'd31;

endpackage

// File: rtl/bus_arbiter_32_rr_pick.sv
// Combinational rotating-priority picker: the first set request at or after last+1
// (modulo NUM_REQ) wins.
module rr_pick
    import bus_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  idx_t               last,
    output logic               found,
    output idx_t               idx,
    output logic [NUM_REQ-1:0] onehot
);

    idx_t cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // i = NUM_REQ wraps back to last itself, giving a full circle
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last + IDX_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        onehot = '0;
        if (found) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter_32.sv
// Round-robin owner-holding arbiter for the 32-source internal CPU bus.
// Optional forced release after MAX_HOLD cycles when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter_32
    import bus_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output idx_t               sel,
    output logic               busy,
    output logic               timeout
);

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("MAX_HOLD must be at least 1");
    end

    logic               state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    idx_t               sel_q, sel_d;
    idx_t               last_q, last_d;
    logic               busy_q;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] pick_onehot;
    idx_t               pick_idx;
    logic               pick_found;
    logic               owner_req;
    logic               expired;
    logic               grant_new;
    logic               rel;

    assign owner_req = req[sel_q];

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] blocked_q, blocked_d;
    logic               timeout_q;

    assign expired = (state_q == OWNED) && owner_req && (cnt_q == CNT_W'(MAX_HOLD - 1));
    // A timed-out source stays masked until it drops its request once
    assign elig    = req & ~blocked_q & ~gnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (grant_new) begin
            cnt_d = '0;
        end else if (state_q == OWNED) begin
            cnt_d = cnt_q + 1'b1;
        end
        blocked_d = (blocked_q & req) | (expired ? gnt_q : '0);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cnt_q     <= '0;
            blocked_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            blocked_q <= blocked_d;
            timeout_q <= expired;
        end
    end

    assign timeout = timeout_q;
`else
    assign expired = 1'b0;
    assign elig    = req & ~gnt_q;
    assign timeout = 1'b0;
`endif

    rr_pick u_pick (
        .req    (elig),
        .last   (last_q),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        grant_new = 1'b0;
        rel       = 1'b0;
        if (state_q == IDLE) begin
            grant_new = en && pick_found;
        end else if (!owner_req || expired) begin
            rel       = 1'b1;
            grant_new = en && pick_found;
        end

        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        if (grant_new) begin
            state_d = OWNED;
            gnt_d   = pick_onehot;
            sel_d   = pick_idx;
            last_d  = pick_idx;
        end else if (rel) begin
            state_d = IDLE;
            gnt_d   = '0;
            sel_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= LAST_RST;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            busy_q  <= (state_d == OWNED);
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule
